// File: rtl/seq_subtractor_64.sv
// seq_subtractor_64: multi-cycle 64-bit subtractor, D = A - B - borrow_in,
// one 16-bit slice per cycle with a registered borrow chain.
//
// Ports:
//   i_clk        rising-edge clock
//   i_reset      asynchronous active-high reset
//   i_start      request, sampled only when not busy
//   i_a, i_b     64-bit minuend / subtrahend, captured on accepted start
//   i_borrow_in  borrow into bit 0, captured on accepted start
//   o_busy       high while slices are being computed
//   o_done       one-cycle pulse, result valid
//   o_d          difference (mod 2^64), filled slice by slice
//   o_borrow_out unsigned borrow, 1 iff A < B + borrow_in
//   o_overflow   signed two's-complement overflow
module seq_subtractor_64 (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    input  logic        i_borrow_in,
    output logic        o_busy,
    output logic        o_done,
    output logic [63:0] o_d,
    output logic        o_borrow_out,
    output logic        o_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [63:0] a_q, a_n;
    logic [63:0] b_q, b_n;
    logic        br_q, br_n;
    logic [1:0]  k_q, k_n;
    logic [63:0] d_q, d_n;
    logic        bo_q, bo_n;
    logic        ov_q, ov_n;

    logic [5:0]  base;
    logic [15:0] a_sl;
    logic [15:0] b_sl;
    logic [16:0] sum;

    // Slice adder: a + ~b + ~borrow; carry-out low means a borrow.
    always_comb begin
        base = {k_q, 4'b0000};
        a_sl = a_q[base +: 16];
        b_sl = b_q[base +: 16];
        sum  = {1'b0, a_sl}
             + {1'b0, ~b_sl}
             + {16'd0, ~br_q};
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            br_q  <= 1'b0;
            k_q   <= 2'd0;
            d_q   <= '0;
            bo_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            state <= state_n;
            a_q   <= a_n;
            b_q   <= b_n;
            br_q  <= br_n;
            k_q   <= k_n;
            d_q   <= d_n;
            bo_q  <= bo_n;
            ov_q  <= ov_n;
        end
    end

    always_comb begin
        state_n = state;
        a_n     = a_q;
        b_n     = b_q;
        br_n    = br_q;
        k_n     = k_q;
        d_n     = d_q;
        bo_n    = bo_q;
        ov_n    = ov_q;
        unique case (state)
            IDLE, DONE: begin
                if (i_start) begin
                    a_n     = i_a;
                    b_n     = i_b;
                    br_n    = i_borrow_in;
                    k_n     = 2'd0;
                    d_n     = '0;
                    state_n = RUN;
                end else if (state == DONE) begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                d_n[base +: 16] = sum[15:0];
                br_n = ~sum[16];
                k_n  = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    bo_n = ~sum[16];
                    // sum[15] is the final d[63] being written now
                    ov_n = (a_q[63] != b_q[63])
                        && (sum[15] != a_q[63]);
                    state_n = DONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign o_busy       = (state == RUN);
    assign o_done       = (state == DONE);
    assign o_d          = d_q;
    assign o_borrow_out = bo_q;
    assign o_overflow   = ov_q;

endmodule

// File: tb/tb_seq_subtractor_64.sv
// tb_seq_subtractor_64: scoreboard bench for seq_subtractor_64.
// Directed corner cases plus randomized operations.
module tb_seq_subtractor_64;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [63:0] d;
    logic        bo;
    logic        ov;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] d;
        logic        bo;
        logic        ov;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] last_d;

    seq_subtractor_64 dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_start(start),
        .i_a(a),
        .i_b(b),
        .i_borrow_in(bin),
        .o_busy(busy),
        .o_done(done),
        .o_d(d),
        .o_borrow_out(bo),
        .o_overflow(ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(
        input logic [63:0] x,
        input logic [63:0] y,
        input logic        c
    );
        exp_t r;
        logic [64:0] u;
        logic signed [65:0] s;
        u = {1'b0, x} - {1'b0, y} - {64'd0, c};
        s = $signed({{2{x[63]}}, x})
          - $signed({{2{y[63]}}, y})
          - $signed({65'd0, c});
        r.d  = u[63:0];
        r.bo = u[64];
        r.ov = (s[65:63] != 3'b000)
            && (s[65:63] != 3'b111);
        return r;
    endfunction

    task automatic chk(
        input string       name,
        input logic [63:0] act,
        input logic [63:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    // Monitor: compare each result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_done: got done=1 expected no result");
            end else begin
                e = sb.pop_front();
                chk("d", d, e.d);
                chk("borrow_out", {63'd0, bo}, {63'd0, e.bo});
                chk("overflow", {63'd0, ov}, {63'd0, e.ov});
            end
        end
    end

    // Drive a start across one rising edge; caller ensures not busy.
    task automatic issue(
        input logic [63:0] x,
        input logic [63:0] y,
        input logic        c
    );
        exp_t e;
        start = 1'b1;
        a     = x;
        b     = y;
        bin   = c;
        e     = model(x, y, c);
        sb.push_back(e);
        last_d = e.d;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // After the accepting edge: busy for 4 samples, then done.
    task automatic wait_done(input bit junk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("busy_run", {63'd0, busy}, 64'd1);
            chk("done_run", {63'd0, done}, 64'd0);
            if (junk && i == 1) begin
                start = 1'b1;
                a     = {$urandom, $urandom};
                b     = {$urandom, $urandom};
                bin   = 1'b1;
            end
            if (junk && i == 2) start = 1'b0;
        end
        @(negedge clk);
        chk("done_pulse", {63'd0, done}, 64'd1);
        chk("busy_done", {63'd0, busy}, 64'd0);
    endtask

    task automatic run_op(
        input logic [63:0] x,
        input logic [63:0] y,
        input logic        c
    );
        issue(x, y, c);
        wait_done(1'b0);
        @(negedge clk);
        chk("done_once", {63'd0, done}, 64'd0);
        chk("d_hold", d, last_d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        last_d = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_d", d, 64'd0);
        chk("rst_bo", {63'd0, bo}, 64'd0);
        chk("rst_ov", {63'd0, ov}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(64'd5, 64'd3, 1'b0);
        run_op(64'd0, 64'd1, 1'b0);
        run_op(64'h1234, 64'h1234, 1'b1);
        run_op(64'h0000_0001_0000_0000, 64'd1, 1'b0);
        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

        // Start during RUN is ignored; start in DONE chains.
        issue(64'hDEAD_BEEF_0000_0000, 64'h1, 1'b0);
        wait_done(1'b1);
        issue(64'd10, 64'd4, 1'b0);
        wait_done(1'b0);
        @(posedge clk);
        #1;

        // Reset mid-run aborts with no result.
        issue(64'h1111_2222_3333_4444, 64'h5, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        void'(sb.pop_back());
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_d", d, 64'd0);
        chk("abort_bo", {63'd0, bo}, 64'd0);
        chk("abort_ov", {63'd0, ov}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("abort_nodone", {63'd0, done}, 64'd0);
        end
        @(posedge clk);
        #1;
        run_op(64'd100, 64'd58, 1'b1);

        // Random operations, some chained back-to-back.
        for (int n = 0; n < 40; n++) begin
            logic [63:0] x;
            logic [63:0] y;
            logic        c;
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            c = 1'($urandom_range(0, 1));
            if (n % 7 == 3) y = x;
            if (n % 5 == 1) begin
                issue(x, y, c);
                wait_done(1'b0);
                issue(y, x, ~c);
                wait_done(1'b0);
                @(posedge clk);
                #1;
            end else begin
                run_op(x, y, c);
            end
        end

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL pending: got %0d outstanding expected 0",
                     sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
